// File: rtl/fft_stage_ctrl.sv
// Sequencer for the 64-point radix-2 FFT stage memory: one input load, STAGES
// butterfly writes with STAGE_LAT settle cycles each, then a held result handshake.
module fft_stage_ctrl #(
  parameter int STAGES    = 6,
  parameter int STAGE_LAT = 2,
  localparam int SW = (STAGES > 1) ? $clog2(STAGES) : 1,
  localparam int CW = (STAGE_LAT > 1) ? $clog2(STAGE_LAT) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          result_ack,
  output logic          write_en,
  output logic          src_sel,
  output logic [SW-1:0] stage,
  output logic          busy,
  output logic          result_valid,
  output logic          overrun
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SETTLE,
    S_WRITE,
    S_HOLD
  } state_t;

  localparam logic [SW-1:0] LAST_STAGE = SW'(STAGES - 1);
  localparam logic [CW-1:0] LAST_CNT   = CW'(STAGE_LAT - 1);

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [SW-1:0] r_stage;
  logic          r_write_en;
  logic          r_src_sel;
  logic          r_busy;
  logic          r_result_valid;
  logic          r_overrun;

  state_t        w_next;
  logic [CW-1:0] w_cnt_next;
  logic [SW-1:0] w_stage_next;
  logic          w_ovr_set;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latches).
    w_next       = r_state;
    w_cnt_next   = r_cnt;
    w_stage_next = r_stage;
    w_ovr_set    = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (start) begin
          w_next       = S_LOAD;
          w_stage_next = '0;
        end
      end
      S_LOAD: begin
        w_ovr_set    = start;
        w_next       = S_SETTLE;
        w_cnt_next   = '0;
        w_stage_next = '0;
      end
      S_SETTLE: begin
        w_ovr_set = start;
        if (r_cnt == LAST_CNT) begin
          w_next = S_WRITE;
        end else begin
          w_cnt_next = r_cnt + CW'(1);
        end
      end
      S_WRITE: begin
        w_ovr_set = start;
        if (r_stage == LAST_STAGE) begin
          w_next = S_HOLD;
        end else begin
          w_next       = S_SETTLE;
          w_stage_next = r_stage + SW'(1);
          w_cnt_next   = '0;
        end
      end
      S_HOLD: begin
        if (result_ack) begin
          // Ack together with start re-launches without passing through IDLE.
          if (start) begin
            w_next       = S_LOAD;
            w_stage_next = '0;
          end else begin
            w_next = S_IDLE;
          end
        end else begin
          w_ovr_set = start;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // NOTE: outputs are registered from the next state, so they line up with r_state
  // and write_en comes straight off a flop with no decode glitches.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: state and outputs use non-blocking assignments so all flops update together.
      r_state        <= S_IDLE;
      r_cnt          <= '0;
      r_stage        <= '0;
      r_write_en     <= 1'b0;
      r_src_sel      <= 1'b0;
      r_busy         <= 1'b0;
      r_result_valid <= 1'b0;
      r_overrun      <= 1'b0;
    end else begin
      r_state        <= w_next;
      r_cnt          <= w_cnt_next;
      r_stage        <= w_stage_next;
      r_write_en     <= (w_next == S_LOAD) || (w_next == S_WRITE);
      r_src_sel      <= (w_next == S_SETTLE) || (w_next == S_WRITE);
      r_busy         <= (w_next == S_LOAD) || (w_next == S_SETTLE) || (w_next == S_WRITE);
      r_result_valid <= (w_next == S_HOLD);
      r_overrun      <= r_overrun | w_ovr_set;
    end
  end

  assign write_en     = r_write_en;
  assign src_sel      = r_src_sel;
  assign stage        = r_stage;
  assign busy         = r_busy;
  assign result_valid = r_result_valid;
  assign overrun      = r_overrun;

endmodule

// File: tb/tb_fft_stage_ctrl.sv
// Bench for fft_stage_ctrl: three instances (STAGE_LAT 2, 1, 4) against a cycle-count
// schedule model, plus directed literal expectations on the pulse timetable.
module tb_fft_stage_ctrl;

  localparam int S = 6;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic result_ack = 1'b0;

  logic       we [3];
  logic       ss [3];
  logic [2:0] stg[3];
  logic       bz [3];
  logic       rv [3];
  logic       ov [3];

  int lat[3] = '{2, 1, 4};

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  fft_stage_ctrl #(.STAGES(S), .STAGE_LAT(2)) u0 (
    .clk(clk), .rst(rst), .start(start), .result_ack(result_ack),
    .write_en(we[0]), .src_sel(ss[0]), .stage(stg[0]), .busy(bz[0]),
    .result_valid(rv[0]), .overrun(ov[0]));
  fft_stage_ctrl #(.STAGES(S), .STAGE_LAT(1)) u1 (
    .clk(clk), .rst(rst), .start(start), .result_ack(result_ack),
    .write_en(we[1]), .src_sel(ss[1]), .stage(stg[1]), .busy(bz[1]),
    .result_valid(rv[1]), .overrun(ov[1]));
  fft_stage_ctrl #(.STAGES(S), .STAGE_LAT(4)) u2 (
    .clk(clk), .rst(rst), .start(start), .result_ack(result_ack),
    .write_en(we[2]), .src_sel(ss[2]), .stage(stg[2]), .busy(bz[2]),
    .result_valid(rv[2]), .overrun(ov[2]));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a transform is just "t cycles since LOAD"; outputs follow from arithmetic on t.
  int m_t[3];
  bit m_hold[3];
  bit m_ovr[3];
  int m_idle_stage[3];
  bit m_ok = 1'b0;

  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (rst) begin
        m_t[i] = 0; m_hold[i] = 0; m_ovr[i] = 0; m_idle_stage[i] = 0;
      end else if (m_t[i] > 0) begin
        if (start) m_ovr[i] = 1;
        if (m_t[i] == 1 + S * (lat[i] + 1)) begin
          m_t[i] = 0; m_hold[i] = 1;
        end else begin
          m_t[i]++;
        end
      end else if (m_hold[i]) begin
        if (result_ack) begin
          m_hold[i] = 0;
          m_idle_stage[i] = S - 1;
          if (start) m_t[i] = 1;
        end else if (start) begin
          m_ovr[i] = 1;
        end
      end else if (start) begin
        m_t[i] = 1;
      end
    end
    if (rst) m_ok = 1'b1;
  end

  always @(negedge clk) begin
    if (m_ok) begin
      for (int i = 0; i < 3; i++) begin
        int t, l, e_st;
        logic e_we, e_ss, e_bz, e_rv;
        t = m_t[i];
        l = lat[i];
        if (t > 0) begin
          e_we = (t == 1) || ((t - 1) % (l + 1) == 0);
          e_ss = (t != 1);
          e_st = (t == 1) ? 0 : (t - 2) / (l + 1);
          e_bz = 1'b1;
          e_rv = 1'b0;
        end else if (m_hold[i]) begin
          e_we = 1'b0; e_ss = 1'b0; e_st = S - 1; e_bz = 1'b0; e_rv = 1'b1;
        end else begin
          e_we = 1'b0; e_ss = 1'b0; e_st = m_idle_stage[i]; e_bz = 1'b0; e_rv = 1'b0;
        end
        check($sformatf("u%0d.write_en", i), 32'(we[i]), 32'(e_we));
        check($sformatf("u%0d.src_sel", i), 32'(ss[i]), 32'(e_ss));
        check($sformatf("u%0d.stage", i), 32'(stg[i]), 32'(e_st));
        check($sformatf("u%0d.busy", i), 32'(bz[i]), 32'(e_bz));
        check($sformatf("u%0d.result_valid", i), 32'(rv[i]), 32'(e_rv));
        check($sformatf("u%0d.overrun", i), 32'(ov[i]), 32'(m_ovr[i]));
      end
    end
  end

  // Per-run history, indexed by cycle number counted from the edge sampling start.
  logic       h_we[3][64];
  logic       h_ss[3][64];
  logic [2:0] h_st[3][64];
  logic       h_bz[3][64];
  logic       h_rv[3][64];
  logic       h_ov[3][64];
  int         last_n;

  // Called at a falling edge (cycle 0); inputs change only on falling edges.
  task automatic run(input int ncyc, input int start_cyc, input int rst_cyc,
                     input int ack_cyc, input logic ack0);
    start = 1'b1;
    result_ack = ack0;
    for (int n = 1; n <= ncyc; n++) begin
      @(negedge clk);
      start = (n == start_cyc);
      rst = (n == rst_cyc);
      result_ack = (n == ack_cyc);
      for (int i = 0; i < 3; i++) begin
        h_we[i][n] = we[i]; h_ss[i][n] = ss[i]; h_st[i][n] = stg[i];
        h_bz[i][n] = bz[i]; h_rv[i][n] = rv[i]; h_ov[i][n] = ov[i];
      end
    end
    last_n = ncyc;
    start = 1'b0;
    rst = 1'b0;
    result_ack = 1'b0;
  endtask

  function automatic int pulse_count(input int i, input int lo, input int hi);
    int c = 0;
    for (int n = lo; n <= hi; n++) if (h_we[i][n] === 1'b1) c++;
    return c;
  endfunction

  function automatic int pulse_at(input int i, input int k);
    int c = 0;
    for (int n = 1; n <= last_n; n++) begin
      if (h_we[i][n] === 1'b1) begin
        if (c == k) return n;
        c++;
      end
    end
    return -1;
  endfunction

  function automatic int wide_pulses(input int i);
    int c = 0;
    for (int n = 1; n < last_n; n++) if (h_we[i][n] === 1'b1 && h_we[i][n+1] === 1'b1) c++;
    return c;
  endfunction

  function automatic int first_rv(input int i);
    for (int n = 1; n <= last_n; n++) if (h_rv[i][n] === 1'b1) return n;
    return -1;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; start = 1'b0; result_ack = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic check_schedule(input string tag);
    int exp_cyc[7] = '{1, 4, 7, 10, 13, 16, 19};
    check({tag, ".pulses"}, 32'(pulse_count(0, 1, last_n)), 32'd7);
    for (int k = 0; k < 7; k++) begin
      check($sformatf("%s.pulse%0d_cycle", tag, k), 32'(pulse_at(0, k)), 32'(exp_cyc[k]));
      if (k > 0) check($sformatf("%s.pulse%0d_stage", tag, k), 32'(h_st[0][exp_cyc[k]]), 32'(k - 1));
    end
    check({tag, ".rv_first"}, 32'(first_rv(0)), 32'd20);
  endtask

  initial begin
    int cnt;

    // Reset values
    do_reset();
    check("reset.write_en", 32'(we[0]), 32'd0);
    check("reset.stage", 32'(stg[0]), 32'd0);
    check("reset.busy", 32'(bz[0]), 32'd0);
    check("reset.result_valid", 32'(rv[0]), 32'd0);
    check("reset.overrun", 32'(ov[0]), 32'd0);

    // Basic run plus STAGE_LAT sweep
    run(40, -1, -1, -1, 1'b0);
    check_schedule("basic");
    check("basic.src_sel_c1", 32'(h_ss[0][1]), 32'd0);
    check("basic.src_sel_c2", 32'(h_ss[0][2]), 32'd1);
    check("basic.src_sel_c4", 32'(h_ss[0][4]), 32'd1);
    check("basic.stage_load", 32'(h_st[0][1]), 32'd0);
    check("basic.busy_c1", 32'(h_bz[0][1]), 32'd1);
    check("basic.busy_c19", 32'(h_bz[0][19]), 32'd1);
    check("basic.busy_c20", 32'(h_bz[0][20]), 32'd0);
    check("basic.rv_c40", 32'(h_rv[0][40]), 32'd1);
    check("lat1.rv_first", 32'(first_rv(1)), 32'd14);
    check("lat4.rv_first", 32'(first_rv(2)), 32'd32);
    check("lat1.pulses", 32'(pulse_count(1, 1, 40)), 32'd7);
    check("lat4.pulses", 32'(pulse_count(2, 1, 40)), 32'd7);
    for (int i = 0; i < 3; i++) check($sformatf("u%0d.wide_pulses", i), 32'(wide_pulses(i)), 32'd0);

    // Back-to-back: start and ack together in HOLD
    run(40, -1, -1, -1, 1'b1);
    check("b2b.load_next", 32'(h_we[0][1]), 32'd1);
    check_schedule("b2b");
    for (int i = 0; i < 3; i++) check($sformatf("b2b.u%0d.overrun", i), 32'(h_ov[i][40]), 32'd0);

    // HOLD without ack for 50 cycles, then a start during HOLD
    cnt = 0;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (rv[0] === 1'b1 && stg[0] === 3'd5 && we[0] === 1'b0) cnt++;
    end
    check("hold50.stable_cycles", 32'(cnt), 32'd50);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("hold.start_overrun", 32'(ov[0]), 32'd1);
    check("hold.still_valid", 32'(rv[0]), 32'd1);
    result_ack = 1'b1;
    @(negedge clk);
    result_ack = 1'b0;
    check("ack.rv_dropped", 32'(rv[0]), 32'd0);
    check("ack.overrun_sticky", 32'(ov[0]), 32'd1);

    // Overrun: extra start at cycle 8
    do_reset();
    run(40, 8, -1, -1, 1'b0);
    check_schedule("ovr");
    check("ovr.c8", 32'(h_ov[0][8]), 32'd0);
    check("ovr.c9", 32'(h_ov[0][9]), 32'd1);
    check("ovr.hold", 32'(h_ov[0][40]), 32'd1);
    result_ack = 1'b1;
    @(negedge clk);
    result_ack = 1'b0;
    @(negedge clk);
    check("ovr.idle", 32'(ov[0]), 32'd1);

    // Reset mid-run at cycle 11, with a stray ack at cycle 5 that must be ignored
    do_reset();
    run(30, -1, 11, 5, 1'b0);
    check("midrst.pulses_before", 32'(pulse_count(0, 1, 11)), 32'd4);
    cnt = 0;
    for (int n = 12; n <= 30; n++)
      if (h_we[0][n] !== 1'b0 || h_ss[0][n] !== 1'b0 || h_st[0][n] !== 3'd0 ||
          h_bz[0][n] !== 1'b0 || h_rv[0][n] !== 1'b0 || h_ov[0][n] !== 1'b0) cnt++;
    check("midrst.nonzero_cycles", 32'(cnt), 32'd0);
    run(10, -1, -1, -1, 1'b0);
    check("restart.load", 32'(h_we[0][1]), 32'd1);
    check("restart.stage_c1", 32'(h_st[0][1]), 32'd0);
    check("restart.pulse_c4", 32'(h_we[0][4]), 32'd1);
    check("restart.stage_c4", 32'(h_st[0][4]), 32'd0);

    // rst and start in the same cycle: reset wins
    rst = 1'b1;
    start = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    start = 1'b0;
    @(negedge clk);
    check("rst_start.busy", 32'(bz[0]), 32'd0);
    check("rst_start.write_en", 32'(we[0]), 32'd0);
    check("rst_start.overrun", 32'(ov[0]), 32'd0);

    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
